adc_scan_scheduler: RTL and testbench

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_spi_frame.sv | 84 ++++++++
 rtl/adc_scan_scheduler.sv | 176 +++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default geometry for the ADC scan scheduler.
// Holds the sequencer state encoding and SPI frame defaults.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } adc_state_e;

  localparam int DEF_SCK_DIV    = 2;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_ADC_BITS   = 12;

endpackage

// File: rtl/adc_spi_frame.sv
// SPI frame engine: SCK divider, bit counter and MSB-first shift register.
// A start pulse launches FRAME_BITS SCK periods; done marks the last cycle.
module adc_spi_frame
  import adc_pkg::*;
#(
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int ADC_BITS   = DEF_ADC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                miso,
  output logic                sck,
  output logic                done,
  output logic [ADC_BITS-1:0] data
);

  localparam int BW = $clog2(FRAME_BITS + 1);

  logic                active_q, active_d;
  logic                sck_q, sck_d;
  logic [7:0]          div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [ADC_BITS-1:0] shreg_q, shreg_d;
  logic                tick;
  logic                last;

  assign tick = (div_q == 8'(SCK_DIV - 1));
  assign last = (bit_q == BW'(FRAME_BITS - 1));

  // Only the trailing ADC_BITS bits of the frame are ever kept.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    done     = 1'b0;
    if (start) begin
      active_d = 1'b1;
      sck_d    = 1'b1;
      div_d    = '0;
      bit_d    = '0;
      shreg_d  = {shreg_q[ADC_BITS-2:0], miso};
    end else if (active_q) begin
      if (tick) begin
        div_d = '0;
        if (sck_q) begin
          sck_d = 1'b0;
        end else if (last) begin
          active_d = 1'b0;
          done     = 1'b1;
        end else begin
          sck_d   = 1'b1;
          bit_d   = bit_q + 1'b1;
          shreg_d = {shreg_q[ADC_BITS-2:0], miso};
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
    end
  end

  assign sck  = sck_q;
  assign data = shreg_q;

endmodule

// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: manual/periodic request arbitration, frame
// sequencing around the SPI engine, and a hysteretic threshold flag.
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int          SCK_DIV    = DEF_SCK_DIV,
  parameter int          FRAME_BITS = DEF_FRAME_BITS,
  parameter int          ADC_BITS   = DEF_ADC_BITS,
  parameter int          PERIOD     = 1000,
  parameter int unsigned THRESH_HI  = 'h800,
  parameter int unsigned THRESH_LO  = 'h700
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_conversion,
  input  logic                auto_en,
  input  logic                miso,
  output logic                cs_n,
  output logic                sck,
  output logic [ADC_BITS-1:0] sample,
  output logic                sample_valid,
  output logic                comparison_result,
  output logic                busy,
  output logic                overrun
);

  localparam int TW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [ADC_BITS-1:0] HI = ADC_BITS'(THRESH_HI);
  localparam logic [ADC_BITS-1:0] LO = ADC_BITS'(THRESH_LO);

  adc_state_e          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                sync1_q, sync2_q, prev_q;
  logic                cs_n_q, cs_n_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic [ADC_BITS-1:0] sample_q, sample_d;
  logic                sv_q, sv_d;
  logic                cmp_q, cmp_d;

  logic                man_req;
  logic                auto_req;
  logic                req;
  logic                tick;
  logic                frame_start;
  logic                frame_done;
  logic                frame_sck;
  logic [ADC_BITS-1:0] frame_data;

  assign man_req  = sync2_q & ~prev_q;
  assign auto_req = auto_en && (timer_q == TW'(PERIOD - 1));
  assign req      = man_req | auto_req;
  assign tick     = (cnt_q == 8'(SCK_DIV - 1));

  always_comb begin
    if (!auto_en || auto_req) timer_d = '0;
    else                      timer_d = timer_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    pend_d      = pend_q;
    ovr_d       = ovr_q;
    sample_d    = sample_q;
    sv_d        = 1'b0;
    cmp_d       = cmp_q;
    frame_start = 1'b0;
    if (req && state_q inside {ST_SETUP, ST_SHIFT, ST_HOLD}) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d     = ST_SHIFT;
          frame_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (frame_done) begin
          state_d = ST_HOLD;
          cs_n_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d  = ST_DONE;
          sample_d = frame_data;
          sv_d     = 1'b1;
          if (frame_data >= HI)     cmp_d = 1'b1;
          else if (frame_data < LO) cmp_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // A fresh request here becomes the new pending one.
        if (pend_q || req) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          pend_d  = pend_q && req;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sample_q <= '0;
      sv_q     <= 1'b0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      sync1_q  <= start_conversion;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cs_n_q   <= cs_n_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      cmp_q    <= cmp_d;
    end
  end

  adc_spi_frame #(
    .SCK_DIV    (SCK_DIV),
    .FRAME_BITS (FRAME_BITS),
    .ADC_BITS   (ADC_BITS)
  ) u_frame (
    .clk   (clk),
    .rst_n (rst_n),
    .start (frame_start),
    .miso  (miso),
    .sck   (frame_sck),
    .done  (frame_done),
    .data  (frame_data)
  );

  assign cs_n              = cs_n_q;
  assign sck               = frame_sck;
  assign sample            = sample_q;
  assign sample_valid      = sv_q;
  assign comparison_result = cmp_q;
  assign busy              = (state_q != ST_IDLE);
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: table vectors, corner sequences and
// random reads checked against a frame/threshold reference model.
module tb_adc_scan_scheduler;

  localparam int P = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_conversion = 1'b0;
  logic        auto_en = 1'b0;
  logic        miso;
  logic        cs_n;
  logic        sck;
  logic [11:0] sample;
  logic        sample_valid;
  logic        comparison_result;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.PERIOD(P)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_conversion  (start_conversion),
    .auto_en           (auto_en),
    .miso              (miso),
    .cs_n              (cs_n),
    .sck               (sck),
    .sample            (sample),
    .sample_valid      (sample_valid),
    .comparison_result (comparison_result),
    .busy              (busy),
    .overrun           (overrun)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ADC slave model: a new 16-bit word per frame, shifted MSB-first
  logic [15:0] force_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_word = 16'h0;
  int          nrise = 0;

  always @(negedge cs_n or posedge sck) begin
    if (!sck) begin
      if (force_q.size() > 0) cur_word = force_q.pop_front();
      else                    cur_word = 16'($urandom);
      exp_q.push_back(cur_word);
      nrise = 0;
    end else begin
      nrise++;
    end
  end

  assign miso = (nrise < 16) ? cur_word[4'(15 - nrise)] : 1'b0;

  // Frame monitor and result model
  int      cyc = 0;
  int      fall_cyc = 0;
  int      sck_cnt = 0;
  int      frames = 0;
  int      sv_cnt = 0;
  int      fall_q[$];
  logic    prev_cs = 1'b1;
  logic    prev_sck = 1'b0;
  logic    model_cmp = 1'b0;

  always @(negedge clk) begin
    logic [15:0] w;
    logic [11:0] es;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      model_cmp = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        fall_cyc = cyc;
        sck_cnt  = 0;
        frames++;
        fall_q.push_back(cyc);
      end
      if (!cs_n && !prev_sck && sck) sck_cnt++;
      if (!prev_cs && cs_n) begin
        check("cs_low_len", 32'(cyc - fall_cyc), 32'd66);
        check("sck_pulses", 32'(sck_cnt), 32'd16);
      end
      if (sample_valid) begin
        sv_cnt++;
        check("sv_latency", 32'(cyc - fall_cyc), 32'd68);
        check("model_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w  = exp_q.pop_front();
          es = w[11:0];
          if (es >= 12'h800)     model_cmp = 1'b1;
          else if (es < 12'h700) model_cmp = 1'b0;
          check("model_sample", 32'(sample), 32'(es));
          check("model_cmp", 32'(comparison_result), 32'(model_cmp));
        end
      end
    end
    prev_cs  = cs_n;
    prev_sck = sck;
  end

  task automatic pulse();
    start_conversion = 1'b1;
    repeat (3) @(negedge clk);
    start_conversion = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_sample;
    logic        exp_cmp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int f0, s0, n;
    logic [15:0] edge_words[4];

    vecs[0] = '{16'h0A5C, 12'hA5C, 1'b1};
    vecs[1] = '{16'h0900, 12'h900, 1'b1};
    vecs[2] = '{16'h0750, 12'h750, 1'b1};
    vecs[3] = '{16'h06FF, 12'h6FF, 1'b0};
    vecs[4] = '{16'h0750, 12'h750, 1'b0};
    vecs[5] = '{16'hF123, 12'h123, 1'b0};
    edge_words[0] = 16'h0800;
    edge_words[1] = 16'h07FF;
    edge_words[2] = 16'h0700;
    edge_words[3] = 16'h06FF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sv", 32'(sample_valid), 32'd0);
    check("rst_cmp", 32'(comparison_result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table: single reads and hysteresis sequence
    for (int i = 0; i < 6; i++) begin
      force_q.push_back(vecs[i].word);
      pulse();
      check("tbl_busy", 32'(busy), 32'd1);
      wait_valid(200, ok);
      check("tbl_timeout", 32'(ok), 32'd1);
      check("tbl_sample", 32'(sample), 32'(vecs[i].exp_sample));
      check("tbl_cmp", 32'(comparison_result), 32'(vecs[i].exp_cmp));
      @(negedge clk);
      check("tbl_sv_1cyc", 32'(sample_valid), 32'd0);
      repeat (5) @(negedge clk);
      check("tbl_hold", 32'(sample), 32'(vecs[i].exp_sample));
    end

    // Auto scan over three periods
    f0 = frames;
    fall_q.delete();
    auto_en = 1'b1;
    repeat (3 * P + 5) @(negedge clk);
    auto_en = 1'b0;
    repeat (120) @(negedge clk);
    check("auto_frames", 32'(frames - f0), 32'd3);
    if (fall_q.size() == 3) begin
      check("auto_gap1", 32'(fall_q[1] - fall_q[0]), P);
      check("auto_gap2", 32'(fall_q[2] - fall_q[1]), P);
    end
    check("auto_ovr", 32'(overrun), 32'd0);

    // Manual edge coinciding with the first timer request
    f0 = frames;
    auto_en = 1'b1;
    repeat (P - 3) @(negedge clk);
    start_conversion = 1'b1;
    repeat (3) @(negedge clk);
    start_conversion = 1'b0;
    repeat (10) @(negedge clk);
    auto_en = 1'b0;
    repeat (150) @(negedge clk);
    check("simul_frames", 32'(frames - f0), 32'd1);
    check("simul_ovr", 32'(overrun), 32'd0);

    // Overrun: two extra edges during one frame
    f0 = frames;
    pulse();
    check("ovr_busy", 32'(busy), 32'd1);
    pulse();
    pulse();
    wait_valid(200, ok);
    check("ovr_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    check("ovr_b2b_cs", 32'(cs_n), 32'd0);
    repeat (200) @(negedge clk);
    check("ovr_frames", 32'(frames - f0), 32'd2);
    check("ovr_flag", 32'(overrun), 32'd1);
    repeat (20) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during SHIFT at bit 7
    pulse();
    for (int i = 0; i < 200 && sck_cnt < 8; i++) @(negedge clk);
    check("mid_reached", 32'(sck_cnt), 32'd8);
    rst_n = 1'b0;
    s0 = sv_cnt;
    @(negedge clk);
    check("mid_cs_n", 32'(cs_n), 32'd1);
    check("mid_sck", 32'(sck), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_sv", 32'(sample_valid), 32'd0);
    check("mid_sample", 32'(sample), 32'd0);
    check("mid_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_no_sv", 32'(sv_cnt), 32'(s0));

    // Random reads, boundary words mixed in
    s0 = sv_cnt;
    n  = 30;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0)
        force_q.push_back(edge_words[$urandom_range(0, 3)]);
      pulse();
      repeat ($urandom_range(72, 110)) @(negedge clk);
    end
    repeat (80) @(negedge clk);
    check("rnd_count", 32'(sv_cnt - s0), 32'(n));
    check("rnd_ovr", 32'(overrun), 32'd0);
    check("rnd_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
